mips_program_checker: RTL and testbench

Reusable, parametrised program-ROM-plus-checker for the MIPS Harvard CPU benches. It serves instructions combinationally on the CPU instruction port from a loadable ROM, so benches no longer need a hard-coded address decoder. It detects program end by a fetch from a halt address, then compares `register_v0` against an expected value. It also enforces a cycle timeout and flags fetches that fall outside the program image.

---
 rtl/mips_program_checker.sv | 219 +++++++++++++++++++++
 tb/tb_mips_program_checker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_program_checker.sv
// ---------------------------------------------------------------------------
// mips_program_checker
//
// Loadable program ROM plus run checker for MIPS Harvard CPU benches.
// The ROM answers CPU instruction fetches combinationally. A small FSM
// watches every fetch during a run:
//   - a fetch from HALT_ADDR ends the run and compares register_v0 with
//     expected_v0 (PASS / FAIL);
//   - a fetch that is neither the halt address nor inside the ROM image
//     ends the run with FAULT;
//   - running out of the cycle budget ends the run with TIMEOUT.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high reset (clears FSM, counters, ROM)
//   clk_enable     low: FSM and counters hold (ROM loads still happen)
//   load_en        ROM write strobe (ignored while a run is in progress)
//   load_index     ROM word index of the write
//   load_data      instruction word to write
//   start          begin / restart a checked run from IDLE or a verdict
//   expected_v0    value register_v0 must hold at the halt fetch
//   instr_address  CPU fetch address
//   instr_readdata instruction word for instr_address (combinational)
//   register_v0    CPU $v0 debug output
//   done           high in any verdict state
//   pass           high only in PASS
//   status         0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 FAULT
//   cycle_count    enabled edges spent in RUN (saturating)
//   fetch_count    in-range fetches sampled in RUN (saturating)
// ---------------------------------------------------------------------------
module mips_program_checker #(
    parameter int          DEPTH        = 16,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter int          TIMEOUT      = 200,
    parameter int          CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [31:0]              load_data,
    input  logic                     start,
    input  logic [31:0]              expected_v0,
    input  logic [31:0]              instr_address,
    output logic [31:0]              instr_readdata,
    input  logic [31:0]              register_v0,
    output logic                     done,
    output logic                     pass,
    output logic [2:0]               status,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         fetch_count
);

    localparam int IDX_W = $clog2(DEPTH);

    // State codes double as the externally visible status encoding, so the
    // status port is the state register itself.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    // Saturating increment shared by both counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    logic [31:0]      rom_r [DEPTH];
    logic [2:0]       state_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic [CNT_W-1:0] fetch_count_r;

    logic [31:0]      offset_s;
    logic [IDX_W-1:0] word_idx_s;
    logic             in_range_s;
    logic             is_halt_s;
    logic             v0_match_s;
    logic             run_edge_s;
    logic             restart_s;
    logic             load_ok_s;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] cycle_nxt_s;
    logic [CNT_W-1:0] fetch_nxt_s;

    // Fetch address decode: offset is taken modulo 2^32, so addresses below
    // the reset vector wrap to huge offsets and fall out of range naturally.
    always_comb begin
        offset_s   = instr_address - RESET_VECTOR;
        word_idx_s = offset_s[IDX_W+1:2];
        in_range_s = (offset_s[1:0] == 2'b00) &&
                     (offset_s[31:IDX_W+2] == {(30-IDX_W){1'b0}});
        is_halt_s  = (instr_address == HALT_ADDR);
        v0_match_s = (register_v0 == expected_v0);
    end

    // Instruction read path; anything outside the image reads as a NOP. A
    // halt address inside the window still returns its ROM word.
    always_comb begin
        if (in_range_s) begin
            instr_readdata = rom_r[word_idx_s];
        end else begin
            instr_readdata = 32'h00000000;
        end
    end

    // Qualifiers for this edge: a RUN cycle, a (re)start, or an allowed load.
    always_comb begin
        run_edge_s = clk_enable && (state_r == ST_RUN);
        restart_s  = clk_enable && start && (state_r != ST_RUN);
        load_ok_s  = load_en && (state_r != ST_RUN);
    end

    // ROM storage: cleared by reset, writable only when no run is active so
    // a bench cannot corrupt the program under the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rom_r[i] <= 32'h00000000;
            end
        end else if (load_ok_s) begin
            rom_r[load_index] <= load_data;
        end
    end

    // Next-state logic. Inside RUN the halt check comes first so a halt on
    // the last budgeted cycle still yields the PASS/FAIL verdict.
    always_comb begin
        state_nxt_s = state_r;
        if (clk_enable) begin
            case (state_r)
                ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT, ST_FAULT: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (is_halt_s) begin
                        if (v0_match_s) begin
                            state_nxt_s = ST_PASS;
                        end else begin
                            state_nxt_s = ST_FAIL;
                        end
                    end else if (!in_range_s) begin
                        state_nxt_s = ST_FAULT;
                    end else if (cycle_count_r == TIMEOUT_LAST) begin
                        state_nxt_s = ST_TIMEOUT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    // Unused encodings recover to IDLE.
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Counter next values: cleared on (re)start, advanced on RUN edges
    // (including the terminating one), frozen otherwise.
    always_comb begin
        cycle_nxt_s = cycle_count_r;
        fetch_nxt_s = fetch_count_r;
        if (restart_s) begin
            cycle_nxt_s = CNT_ZERO;
            fetch_nxt_s = CNT_ZERO;
        end else if (run_edge_s) begin
            cycle_nxt_s = sat_inc(cycle_count_r);
            if (in_range_s) begin
                fetch_nxt_s = sat_inc(fetch_count_r);
            end else begin
                fetch_nxt_s = fetch_count_r;
            end
        end else begin
            cycle_nxt_s = cycle_count_r;
            fetch_nxt_s = fetch_count_r;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cycle_count_r <= CNT_ZERO;
            fetch_count_r <= CNT_ZERO;
        end else begin
            state_r       <= state_nxt_s;
            cycle_count_r <= cycle_nxt_s;
            fetch_count_r <= fetch_nxt_s;
        end
    end

    // Verdict outputs are pure decodes of registers, so they cannot glitch.
    assign status      = state_r;
    assign done        = (state_r == ST_PASS)    || (state_r == ST_FAIL) ||
                         (state_r == ST_TIMEOUT) || (state_r == ST_FAULT);
    assign pass        = (state_r == ST_PASS);
    assign cycle_count = cycle_count_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_mips_program_checker.sv
// ---------------------------------------------------------------------------
// tb_mips_program_checker
//
// Two checker instances share every input: "a" with TIMEOUT=8 and "b" with
// TIMEOUT=4. A behavioural model (status as an integer, counts as integers,
// ROM as an array) predicts both instances; a compare process checks every
// output of both on each falling edge. Directed literal checks pin the
// model at the interesting points of each scenario.
// ---------------------------------------------------------------------------
module tb_mips_program_checker;

    localparam int          DEPTH = 16;
    localparam logic [31:0] RV    = 32'hBFC00000;
    localparam logic [31:0] HALT  = 32'h00000000;
    localparam int          T_A   = 8;
    localparam int          T_B   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        load_en;
    logic [3:0]  load_index;
    logic [31:0] load_data;
    logic        start;
    logic [31:0] expected_v0;
    logic [31:0] instr_address;
    logic [31:0] register_v0;

    logic [31:0] rd_a, rd_b;
    logic        done_a, done_b, pass_a, pass_b;
    logic [2:0]  status_a, status_b;
    logic [15:0] cyc_a, cyc_b, fch_a, fch_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prog [5] = '{32'h3C010001, 32'h3C030004, 32'h00231021,
                              32'h00000008, 32'h24000000};

    always #5 clk = ~clk;

    mips_program_checker #(.DEPTH(DEPTH), .RESET_VECTOR(RV), .HALT_ADDR(HALT),
                           .TIMEOUT(T_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .load_en(load_en),
        .load_index(load_index), .load_data(load_data), .start(start),
        .expected_v0(expected_v0), .instr_address(instr_address),
        .instr_readdata(rd_a), .register_v0(register_v0), .done(done_a),
        .pass(pass_a), .status(status_a), .cycle_count(cyc_a), .fetch_count(fch_a));

    mips_program_checker #(.DEPTH(DEPTH), .RESET_VECTOR(RV), .HALT_ADDR(HALT),
                           .TIMEOUT(T_B), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .load_en(load_en),
        .load_index(load_index), .load_data(load_data), .start(start),
        .expected_v0(expected_v0), .instr_address(instr_address),
        .instr_readdata(rd_b), .register_v0(register_v0), .done(done_b),
        .pass(pass_b), .status(status_b), .cycle_count(cyc_b), .fetch_count(fch_b));

    // ---------------- behavioural model ----------------
    // status: 0 idle, 1 run, 2 pass, 3 fail, 4 timeout, 5 fault
    int          m_st  [2];
    int          m_cyc [2];
    int          m_fch [2];
    logic [31:0] m_rom [2][DEPTH];

    function automatic bit in_window(input logic [31:0] a);
        logic [31:0] off;
        off = a - RV;
        return ((off % 32'd4) == 32'd0) && ((off / 32'd4) < 32'(DEPTH));
    endfunction

    function automatic int budget(input int i);
        return (i == 0) ? T_A : T_B;
    endfunction

    function automatic logic [31:0] exp_rd(input int i);
        logic [31:0] off;
        off = instr_address - RV;
        if (in_window(instr_address)) return m_rom[i][int'(off / 32'd4)];
        return 32'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i]  <= 0;
                m_cyc[i] <= 0;
                m_fch[i] <= 0;
                for (int w = 0; w < DEPTH; w++) m_rom[i][w] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load_en && m_st[i] != 1) m_rom[i][load_index] <= load_data;
                if (clk_enable) begin
                    if (m_st[i] != 1) begin
                        if (start) begin
                            m_st[i]  <= 1;
                            m_cyc[i] <= 0;
                            m_fch[i] <= 0;
                        end
                    end else begin
                        m_cyc[i] <= (m_cyc[i] < 65535) ? m_cyc[i] + 1 : m_cyc[i];
                        if (in_window(instr_address) && m_fch[i] < 65535)
                            m_fch[i] <= m_fch[i] + 1;
                        if (instr_address == HALT)
                            m_st[i] <= (register_v0 == expected_v0) ? 2 : 3;
                        else if (!in_window(instr_address))
                            m_st[i] <= 5;
                        else if (m_cyc[i] + 1 >= budget(i))
                            m_st[i] <= 4;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input int i, input string tag, input logic [31:0] rd,
                                input logic [2:0] st, input logic dn, input logic ps,
                                input logic [15:0] cy, input logic [15:0] fc);
        check({tag, ".readdata"}, rd, exp_rd(i));
        check({tag, ".status"}, {29'd0, st}, m_st[i]);
        check({tag, ".done"}, {31'd0, dn}, (m_st[i] >= 2) ? 32'd1 : 32'd0);
        check({tag, ".pass"}, {31'd0, ps}, (m_st[i] == 2) ? 32'd1 : 32'd0);
        check({tag, ".cycle_count"}, {16'd0, cy}, m_cyc[i]);
        check({tag, ".fetch_count"}, {16'd0, fc}, m_fch[i]);
    endtask

    // Model-versus-DUT comparison, away from the active edge.
    always @(negedge clk) begin
        compare_inst(0, "a", rd_a, status_a, done_a, pass_a, cyc_a, fch_a);
        compare_inst(1, "b", rd_b, status_b, done_b, pass_b, cyc_b, fch_b);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int k = 0; k < n; k++) begin
            load_en    = 1'b1;
            load_index = 4'(k);
            load_data  = prog[k];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_prog(input logic [31:0] v0_at_halt);
        for (int k = 0; k < 5; k++) begin
            instr_address = RV + 32'(4 * k);
            #1;
            check("prog.readdata", rd_a, prog[k]);
            tick();
        end
        instr_address = HALT;
        register_v0   = v0_at_halt;
        tick();
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; load_en = 1'b0; load_index = 4'd0;
        load_data = 32'h0; start = 1'b0; expected_v0 = 32'h0;
        instr_address = 32'h0; register_v0 = 32'h0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("reset.status", {29'd0, status_a}, 32'd0);
        check("reset.done", {31'd0, done_a}, 32'd0);
        check("reset.cycle_count", {16'd0, cyc_a}, 32'd0);
        instr_address = RV;
        #1;
        check("reset.rom", rd_a, 32'h0);

        // LUI program, passing
        load_words(5);
        expected_v0 = 32'h00050000;
        do_start();
        check("lui.start_status", {29'd0, status_a}, 32'd1);
        run_prog(32'h00050000);
        check("lui.status", {29'd0, status_a}, 32'd2);
        check("lui.pass", {31'd0, pass_a}, 32'd1);
        check("lui.cycle_count", {16'd0, cyc_a}, 32'd6);
        check("lui.fetch_count", {16'd0, fch_a}, 32'd5);
        check("lui.b_timeout", {29'd0, status_b}, 32'd4);

        // Wrong value, restarted from PASS
        register_v0 = 32'h0;
        do_start();
        check("wrong.restart_cycles", {16'd0, cyc_a}, 32'd0);
        run_prog(32'h00040000);
        check("wrong.status", {29'd0, status_a}, 32'd3);
        check("wrong.pass", {31'd0, pass_a}, 32'd0);
        check("wrong.done", {31'd0, done_a}, 32'd1);

        // Timeout, with an ignored load, an ignored start and a pause
        instr_address = RV;
        do_start();
        tick();
        load_en = 1'b1; load_index = 4'd5; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("timeout.cycles4", {16'd0, cyc_a}, 32'd4);
        clk_enable = 1'b0;
        tick(); tick(); tick();
        check("timeout.paused_cycles", {16'd0, cyc_a}, 32'd4);
        check("timeout.paused_status", {29'd0, status_a}, 32'd1);
        clk_enable = 1'b1;
        tick(); tick(); tick();
        check("timeout.edge7_status", {29'd0, status_a}, 32'd1);
        tick();
        check("timeout.status", {29'd0, status_a}, 32'd4);
        check("timeout.cycle_count", {16'd0, cyc_a}, 32'd8);
        instr_address = RV + 32'd20;
        #1;
        check("timeout.load_ignored", rd_a, 32'h0);

        // Halt on the last budgeted edge of instance b
        expected_v0 = 32'h00050000;
        register_v0 = 32'h00050000;
        do_start();
        for (int k = 0; k < 3; k++) begin
            instr_address = RV + 32'(4 * k);
            tick();
        end
        instr_address = HALT;
        tick();
        check("collide.status", {29'd0, status_b}, 32'd2);
        check("collide.cycle_count", {16'd0, cyc_b}, 32'd4);

        // Misaligned fetch faults; out-of-range reads are NOPs
        do_start();
        instr_address = RV + 32'd2;
        #1;
        check("fault.misaligned_rd", rd_a, 32'h0);
        tick();
        check("fault.status", {29'd0, status_a}, 32'd5);
        check("fault.cycle_count", {16'd0, cyc_a}, 32'd1);
        instr_address = RV + 32'(4 * DEPTH);
        #1;
        check("fault.oor_rd", rd_a, 32'h0);
        do_start();
        tick();
        check("fault.oor_status", {29'd0, status_a}, 32'd5);

        // Reset mid-run, then reload with a load+start edge and rerun
        instr_address = RV;
        do_start();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("midreset.status", {29'd0, status_a}, 32'd0);
        check("midreset.cycle_count", {16'd0, cyc_a}, 32'd0);
        check("midreset.fetch_count", {16'd0, fch_a}, 32'd0);
        check("midreset.rom", rd_a, 32'h0);
        reset = 1'b0;
        load_words(4);
        load_en = 1'b1; load_index = 4'd4; load_data = prog[4];
        do_start();
        load_en = 1'b0;
        check("rerun.start_status", {29'd0, status_a}, 32'd1);
        instr_address = RV + 32'd16;
        #1;
        check("rerun.loaded_word", rd_a, 32'h24000000);
        run_prog(32'h00050000);
        check("rerun.status", {29'd0, status_a}, 32'd2);
        check("rerun.cycle_count", {16'd0, cyc_a}, 32'd6);
        do_start();
        check("again.status", {29'd0, status_a}, 32'd1);
        check("again.cycle_count", {16'd0, cyc_a}, 32'd0);
        check("again.fetch_count", {16'd0, fch_a}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
